// File: rtl/nios_upc_pio_in.sv
// Avalon-MM parallel input port: synchronizes WIDTH external pins, detects edges
// into a sticky write-1-to-clear capture register and raises a maskable level irq.
module nios_upc_pio_in #(
  parameter int WIDTH     = 8,  // 1..32
  parameter int EDGE_TYPE = 0   // 0 = rising, 1 = falling, 2 = any
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } reg_addr_e;

  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_mask;
  logic             wr_en;
  logic             unused_wdata;

  // Upper writedata bits are architecturally ignored.
  assign unused_wdata = ^writedata;

  always_comb begin
    case (EDGE_TYPE)
      1:       edge_det = ~s2_q & s3_q;
      2:       edge_det = s2_q ^ s3_q;
      default: edge_det = s2_q & ~s3_q;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_en     = chipselect & ~write_n;
    irqmask_d = irqmask_q;
    clr_mask  = '0;
    if (wr_en && reg_addr_e'(address) == ADDR_IRQMASK) irqmask_d = writedata[WIDTH-1:0];
    if (wr_en && reg_addr_e'(address) == ADDR_EDGECAP) clr_mask  = writedata[WIDTH-1:0];
    // A new edge beats a simultaneous clear of the same bit.
    edgecap_d = (edgecap_q & ~clr_mask) | edge_det;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      s1_q      <= in_port;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (reg_addr_e'(address))
      ADDR_DATA:    readdata = 32'(s2_q);
      ADDR_IRQMASK: readdata = 32'(irqmask_q);
      ADDR_EDGECAP: readdata = 32'(edgecap_q);
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_upc_pio_in.sv
// Randomized bench for nios_upc_pio_in: three instances (rising/falling/any edge)
// share one bus and pin set and are compared with a pin-history reference model.
module tb_nios_upc_pio_in;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_r, rd_f, rd_a;
  logic          irq_r, irq_f, irq_a;

  always #10 clk = ~clk;

  nios_upc_pio_in #(.WIDTH(W), .EDGE_TYPE(0)) dut_r (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_r), .irq(irq_r));
  nios_upc_pio_in #(.WIDTH(W), .EDGE_TYPE(1)) dut_f (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_f), .irq(irq_f));
  nios_upc_pio_in #(.WIDTH(W), .EDGE_TYPE(2)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: pin value seen at every clock edge, plus the index of the
  // most recent reset edge. Anything at or before that edge reads back as zero.
  logic [W-1:0] pin_log [0:8191];
  int           n_edge   = 0;
  int           last_rst = 0;
  logic [W-1:0] m_mask;
  logic [W-1:0] m_cap [3];

  function automatic logic [W-1:0] samp(input int j);
    if (j < 1 || j <= last_rst) return '0;
    return pin_log[j];
  endfunction

  // DATA shows the pins as sampled one edge ago; an edge is seen when the value
  // sampled two edges ago differs from the one sampled three edges ago.
  task automatic model_edge();
    logic [W-1:0] now_v, old_v, clr;
    logic         wr;
    n_edge++;
    pin_log[n_edge] = in_port;
    wr = chipselect && !write_n;
    if (reset) begin
      last_rst = n_edge;
      m_mask   = '0;
      for (int t = 0; t < 3; t++) m_cap[t] = '0;
    end else begin
      now_v = samp(n_edge - 2);
      old_v = samp(n_edge - 3);
      clr   = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      m_cap[0] = (m_cap[0] & ~clr) | (now_v & ~old_v);
      m_cap[1] = (m_cap[1] & ~clr) | (~now_v & old_v);
      m_cap[2] = (m_cap[2] & ~clr) | (now_v ^ old_v);
      if (wr && address == 2'd2) m_mask = writedata[W-1:0];
    end
  endtask

  function automatic logic [31:0] exp_rd(input int t, input int a);
    case (a)
      0:       return {24'd0, samp(n_edge - 1)};
      2:       return {24'd0, m_mask};
      3:       return {24'd0, m_cap[t]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    logic [1:0] save;
    save = address;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check($sformatf("%s.rd%0d.rise", tag, a), rd_r, exp_rd(0, a));
      check($sformatf("%s.rd%0d.fall", tag, a), rd_f, exp_rd(1, a));
      check($sformatf("%s.rd%0d.any",  tag, a), rd_a, exp_rd(2, a));
    end
    address = save;
    #1;
    check({tag, ".irq.rise"}, 32'(irq_r), 32'(|(m_cap[0] & m_mask)));
    check({tag, ".irq.fall"}, 32'(irq_f), 32'(|(m_cap[1] & m_mask)));
    check({tag, ".irq.any"},  32'(irq_a), 32'(|(m_cap[2] & m_mask)));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_regs(tag);
  endtask

  task automatic peek(input int t, input logic [1:0] a, output logic [31:0] v);
    logic [1:0] save;
    save    = address;
    address = a;
    #1;
    case (t)
      0:       v = rd_r;
      1:       v = rd_f;
      default: v = rd_a;
    endcase
    address = save;
    #1;
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick("wr");
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    reset   = 1'b1;
    address = 2'd0;
    in_port = '0;
    bus_idle();
    repeat (3) tick("reset");
    check("reset.irq", 32'(irq_r), 32'd0);
    reset = 1'b0;
    repeat (3) tick("idle");

    // 0x00 -> 0x05: DATA after k+1, EDGECAPTURE after k+2, no irq with mask 0
    in_port = 8'h05;
    tick("k");
    peek(0, 2'd0, v); check("lat.data_k", v, 32'h0);
    tick("k1");
    peek(0, 2'd0, v); check("lat.data_k1", v, 32'h05);
    peek(0, 2'd3, v); check("lat.cap_k1", v, 32'h0);
    tick("k2");
    peek(0, 2'd3, v); check("lat.cap_k2", v, 32'h05);
    check("lat.irq_k2", 32'(irq_r), 32'd0);

    // Masked irq on bit 2, then write-1-to-clear keeps the other bits
    wr(2'd3, 32'hFF);
    in_port = 8'h00;
    repeat (3) tick("fall0");
    wr(2'd2, 32'h04);
    in_port = 8'h01;
    repeat (3) tick("b0");
    in_port = 8'h05;
    tick("b2a");
    tick("b2b");
    check("mask.irq_early", 32'(irq_r), 32'd0);
    tick("b2c");
    check("mask.irq_set", 32'(irq_r), 32'd1);
    wr(2'd3, 32'h04);
    check("mask.irq_clr", 32'(irq_r), 32'd0);
    peek(0, 2'd3, v); check("mask.cap_kept", v, 32'h01);

    // Rising bit 3 lands on the same edge as its clear: the set wins
    in_port = 8'h0D;
    tick("b3a");
    tick("b3b");
    wr(2'd3, 32'h08);
    peek(0, 2'd3, v); check("setwins.cap", v, 32'h09);

    // Falling edge on bit 0 seen by falling/any, rising edge not seen by falling
    wr(2'd3, 32'hFF);
    in_port = 8'h0C;
    repeat (3) tick("fe");
    peek(2, 2'd3, v); check("edge.any_fall", v & 32'h1, 32'h1);
    peek(1, 2'd3, v); check("edge.fall_fall", v & 32'h1, 32'h1);
    peek(0, 2'd3, v); check("edge.rise_fall", v & 32'h1, 32'h0);
    wr(2'd3, 32'hFF);
    in_port = 8'h0D;
    repeat (3) tick("re");
    peek(1, 2'd3, v); check("edge.fall_rise", v & 32'h1, 32'h0);
    peek(2, 2'd3, v); check("edge.any_rise", v & 32'h1, 32'h1);

    // Reset mid-operation with pending captures and a full mask
    wr(2'd2, 32'hFF);
    check("rst.irq_before", 32'(irq_a), 32'd1);
    reset = 1'b1;
    tick("rst_mid");
    reset = 1'b0;
    peek(2, 2'd3, v); check("rst.cap", v, 32'h0);
    peek(2, 2'd2, v); check("rst.mask", v, 32'h0);
    check("rst.irq", 32'(irq_a), 32'd0);
    tick("rst_p1");
    tick("rst_p2");
    peek(0, 2'd3, v); check("rst.cap_p2", v, 32'h0);
    tick("rst_p3");
    peek(0, 2'd3, v); check("rst.cap_p3", v, 32'h0D);

    // Writes to DATA and the reserved address change nothing
    wr(2'd2, 32'hFFFF_FF5A);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    peek(0, 2'd2, v); check("ro.mask", v, 32'h5A);
    peek(0, 2'd3, v); check("ro.cap", v, 32'h0D);
    peek(0, 2'd1, v); check("ro.rsvd", v, 32'h0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      chipselect = $urandom_range(0, 1) == 1;
      write_n    = $urandom_range(0, 1) == 1;
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
      tick("rand");
    end
    reset = 1'b0;
    bus_idle();
    tick("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
